// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch front-end types and defaults.
// Contents: XLEN, default reset/trap vectors, sequencer FSM state enum.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VECTOR_DEF = 32'h0000_0100;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} seq_state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch sequencer bus bundle.
// Signals: redirect/trap/stall control in, instruction memory request/response,
// decoded instruction out (instr, pc, pc+4) and misalign pulse.
// master = sequencer side, slave = core/memory environment side.
interface pc_sequencer_if;
    import cpu_pkg::*;
    logic            redirect_valid_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            trap_i;
    logic            stall_i;
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_ack_i;
    logic [XLEN-1:0] imem_rdata_i;
    logic            instr_valid_o;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] instr_pc_o;
    logic [XLEN-1:0] pc_four_o;
    logic            misalign_o;
    modport master (
        input  redirect_valid_i, redirect_pc_i, trap_i, stall_i, imem_ack_i, imem_rdata_i,
        output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, pc_four_o, misalign_o
    );
    modport slave (
        output redirect_valid_i, redirect_pc_i, trap_i, stall_i, imem_ack_i, imem_rdata_i,
        input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o, pc_four_o, misalign_o
    );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-pc priority mux (trap > redirect > pc+4).
// Ports: pc, trap, redirect_valid, redirect_pc in; next_pc, flush (any
// trap/redirect), take_trap (target is the trap vector), misalign out.
// Macro PC_SEQ_MISALIGN_TRAP_EN: a misaligned redirect becomes a trap and
// raises misalign; otherwise the target's low two bits are forced to zero.
module pc_next_sel
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VECTOR = TRAP_VECTOR_DEF
) (
    input  logic [XLEN-1:0] pc,
    input  logic            trap,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] next_pc,
    output logic            flush,
    output logic            take_trap,
    output logic            misalign
);
    logic [XLEN-1:0] target;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    assign target   = redirect_pc;
    assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    logic unused_low;
    assign unused_low = ^redirect_pc[1:0];
    assign target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign misalign   = 1'b0;
`endif
    assign take_trap = trap || misalign;
    assign flush     = trap || redirect_valid;
    assign next_pc   = take_trap ? TRAP_VECTOR : redirect_valid ? target : pc + XLEN'(4);
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch sequencer (IDLE/FETCH/HOLD/DRAIN).
// Ports: clk_i, reset (async active-low), bus (pc_sequencer_if.master).
// Params: RESET_VECTOR, TRAP_VECTOR.
// Macro PC_SEQ_MISALIGN_TRAP_EN: misaligned redirects trap and pulse misalign_o.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
    input  logic               clk_i,
    input  logic               reset,
    pc_sequencer_if.master     bus
);
    seq_state_t      state, state_d;
    logic [XLEN-1:0] pc, pc_d, pend_pc, pend_pc_d, instr, instr_d, instr_pc, instr_pc_d, next_pc;
    logic            pend_trap, pend_trap_d, valid, valid_d, misalign_q, flush, take_trap, misalign;

    pc_next_sel #(.TRAP_VECTOR(TRAP_VECTOR)) u_sel (
        .pc             (pc),
        .trap           (bus.trap_i),
        .redirect_valid (bus.redirect_valid_i),
        .redirect_pc    (bus.redirect_pc_i),
        .next_pc        (next_pc),
        .flush          (flush),
        .take_trap      (take_trap),
        .misalign       (misalign)
    );

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pc         <= RESET_VECTOR;
            pend_pc    <= RESET_VECTOR;
            pend_trap  <= 1'b0;
            instr      <= '0;
            instr_pc   <= '0;
            valid      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            pend_pc    <= pend_pc_d;
            pend_trap  <= pend_trap_d;
            instr      <= instr_d;
            instr_pc   <= instr_pc_d;
            valid      <= valid_d;
            misalign_q <= misalign;
        end
    end

    always_comb begin
        state_d     = state;
        pc_d        = pc;
        pend_pc_d   = pend_pc;
        pend_trap_d = pend_trap;
        instr_d     = instr;
        instr_pc_d  = instr_pc;
        valid_d     = valid;
        case (state)
            IDLE: begin
                state_d = FETCH;
                pc_d    = flush ? next_pc : pc;
            end
            FETCH: begin
                valid_d = 1'b0;
                if (bus.imem_ack_i && !flush) begin
                    instr_d    = bus.imem_rdata_i;
                    instr_pc_d = pc;
                    valid_d    = 1'b1;
                    // stall only applies to an instruction actually being presented
                    if (bus.stall_i && valid)
                        state_d = HOLD;
                    else
                        pc_d = next_pc;
                end else if (bus.imem_ack_i) begin
                    pc_d = next_pc;
                end else if (flush) begin
                    // the outstanding request cannot be aborted; park the target
                    pend_pc_d   = next_pc;
                    pend_trap_d = take_trap;
                    state_d     = DRAIN;
                end
            end
            HOLD: begin
                if (flush || !bus.stall_i) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                valid_d = 1'b0;
                // a pending trap outranks any later redirect
                if (flush && (take_trap || !pend_trap)) begin
                    pend_pc_d   = next_pc;
                    pend_trap_d = take_trap || pend_trap;
                end
                if (bus.imem_ack_i) begin
                    pc_d        = pend_pc_d;
                    pend_trap_d = 1'b0;
                    state_d     = FETCH;
                end
            end
        endcase
    end

    assign bus.imem_req_o    = (state == FETCH) || (state == DRAIN);
    assign bus.imem_addr_o   = pc;
    assign bus.instr_valid_o = valid;
    assign bus.instr_o       = instr;
    assign bus.instr_pc_o    = instr_pc;
    assign bus.pc_four_o     = instr_pc + XLEN'(4);
    assign bus.misalign_o    = misalign_q;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, 32'h0000_0100, fetch address taken on trap.
REQ-003 clk_i  input  1  clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 redirect_valid_i  input  1  branch/jump taken, one-cycle pulse.
REQ-006 redirect_pc_i  input  32  branch/jump target, valid with redirect_valid_i.
REQ-007 trap_i  input  1  trap request, one-cycle pulse.
REQ-008 stall_i  input  1  downstream cannot accept the presented instruction.
REQ-009 imem_req_o  output  1  instruction memory request.
REQ-010 imem_addr_o  output  32  fetch address, stable while imem_req_o high.
REQ-011 imem_ack_i  input  1  memory response, may arrive in the request cycle or later.
REQ-012 imem_rdata_i  input  32  instruction word, valid with imem_ack_i.
REQ-013 instr_valid_o  output  1  instr_o/instr_pc_o hold a valid instruction.
REQ-014 instr_o  output  32  fetched instruction.
REQ-015 instr_pc_o  output  32  address of instr_o.
REQ-016 pc_four_o  output  32  instr_pc_o + 4, modulo 2^32.
REQ-017 misalign_o  output  1  one-cycle pulse: redirect target not word-aligned.

Function
REQ-018 FSM states IDLE, FETCH, HOLD, DRAIN; IDLE -> FETCH unconditionally one cycle after reset release.
REQ-019 FETCH: imem_req_o=1, imem_addr_o=pc; remain until imem_ack_i.
REQ-020 On ack in FETCH with no pending flush: instr_o<=imem_rdata_i, instr_pc_o<=pc, instr_valid_o<=1 at that edge.
REQ-021 On accepted ack with stall_i=0: pc<=next_pc, stay FETCH; zero-wait memory gives one instruction per cycle.
REQ-022 On accepted ack with stall_i=1: go HOLD; pc unchanged; imem_req_o=0.
REQ-023 HOLD: outputs frozen, instr_valid_o=1; on stall_i=0, pc<=next_pc, instr_valid_o<=0, go FETCH.
REQ-024 next_pc priority: trap (TRAP_VECTOR) > redirect (redirect_pc_i) > pc+4; pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-025 Trap/redirect while imem_req_o=1 and no ack that cycle: record target in pending register, go DRAIN; request never aborted.
REQ-026 DRAIN: imem_req_o=1 on old address until ack; response discarded (instr_valid_o=0); pc<=pending target; go FETCH.
REQ-027 Trap/redirect in same cycle as ack, or in HOLD: pc<=target directly, fetched/held instruction invalidated next edge, go FETCH.
REQ-028 Later trap in DRAIN overwrites pending target; later redirect in DRAIN ignored if trap pending.
REQ-029 Trap/redirect in IDLE: pc<=target, next state FETCH.
REQ-030 stall_i has no effect while instr_valid_o=0.

Reset
REQ-031 reset low: state IDLE, pc=RESET_VECTOR, imem_req_o=0, imem_addr_o=RESET_VECTOR, instr_valid_o=0, instr_o=0, instr_pc_o=0, pc_four_o=4, misalign_o=0, pending cleared.
REQ-032 Reset mid-fetch abandons outstanding request; acks during reset ignored.

Configuration
REQ-033 Macro PC_SEQ_MISALIGN_TRAP_EN.
REQ-034 Defined: redirect with redirect_pc_i[1:0]!=0 pulses misalign_o and uses TRAP_VECTOR as target (same priority/drain rules as trap).
REQ-035 Undefined: redirect_pc_i[1:0] forced to 0; misalign_o tied 0.

Structure
REQ-036 Shared package cpu_pkg: FSM state enum, XLEN=32, RESET_VECTOR/TRAP_VECTOR defaults.
REQ-037 Sub-module pc_next_sel: combinational priority mux + pc+4 adder + alignment check.

Verification
REQ-038 Reset release, ack tied 1 -> imem_addr_o 0x0,0x4,0x8 on consecutive cycles; instr_pc_o follows one cycle later.
REQ-039 Ack delayed 3 cycles at 0x8 -> imem_req_o/imem_addr_o=0x8 held 3 cycles; one instr_valid_o with instr_pc_o=0x8, pc_four_o=0xC.
REQ-040 stall_i=1 for 4 cycles after fetch at 0x4 -> instr_o/instr_pc_o=0x4 frozen, imem_req_o=0; then fetch 0x8.
REQ-041 Redirect 0x200 while ack pending at 0x10 -> request at 0x10 completes, discarded; next fetch 0x200.
REQ-042 Trap and redirect 0x300 same cycle -> next fetch 0x100.
REQ-043 Macro defined, redirect 0x202 -> misalign_o one pulse, next fetch 0x100; undefined -> next fetch 0x200, misalign_o=0.
